// File: rtl/block_serial_subtractor_pkg.sv
// Shared definitions for the block-serial subtractor: FSM encoding and sizing helpers.
package block_serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int stages_count(input int data_width, input int block_size);
    return data_width / block_size;
  endfunction

  // A single-stage build still needs a one-bit counter.
  function automatic int cnt_width(input int stages);
    return (stages <= 1) ? 1 : $clog2(stages);
  endfunction

endpackage

// File: rtl/block_subtract_bypass.sv
// One BLOCK_SIZE-bit slice of a - b - borrow_in with a propagate bypass on the borrow chain.
// With add = 1 the slice computes a + b + borrow_in and borrow_out carries the carry-out.
module block_subtract_bypass #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         borrow_in,
  input  logic         add,
  output logic [W-1:0] diff,
  output logic         borrow_out
);

  logic [W-1:0] b_eff;
  logic         c_in;
  logic [W:0]   sum;
  logic [W-1:0] prop;

  assign b_eff = add ? b : ~b;
  assign c_in  = add ? borrow_in : ~borrow_in;
  assign sum   = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, c_in};
  assign prop  = a ^ b_eff;
  assign diff  = sum[W-1:0];

  // A fully propagating block forwards its incoming borrow untouched.
  assign borrow_out = (&prop) ? borrow_in : (add ? sum[W] : ~sum[W]);

endmodule

// File: rtl/block_serial_subtractor.sv
// Multi-cycle D = A - B - Bin, one BLOCK_SIZE slice per clock, LSB slice first.
// Define SUBTRACTOR_ADD_MODE_EN to add an op port selecting A + B + Bin.
module block_serial_subtractor #(
  parameter int DATA_WIDTH = 16,
  parameter int BLOCK_SIZE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  Bin,
`ifdef SUBTRACTOR_ADD_MODE_EN
  input  logic                  op,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] D,
  output logic                  BF,
  output logic                  OF
);
  import block_serial_subtractor_pkg::*;

  localparam int STAGES = stages_count(DATA_WIDTH, BLOCK_SIZE);
  localparam int CW     = cnt_width(STAGES);
  localparam int LAST   = STAGES - 1;

  if (DATA_WIDTH % BLOCK_SIZE != 0) begin : g_width_check
    $error("DATA_WIDTH must be a multiple of BLOCK_SIZE");
  end

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] a_reg, b_reg, d_reg;
  logic                  borrow_reg, bf_reg, of_reg, op_reg;
  logic [CW-1:0]         cnt_reg;

  logic [BLOCK_SIZE-1:0] a_blocks [STAGES];
  logic [BLOCK_SIZE-1:0] b_blocks [STAGES];
  logic [BLOCK_SIZE-1:0] blk_diff;
  logic                  blk_borrow;
  logic                  last_blk, of_calc;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_slices
    assign a_blocks[gi] = a_reg[gi*BLOCK_SIZE +: BLOCK_SIZE];
    assign b_blocks[gi] = b_reg[gi*BLOCK_SIZE +: BLOCK_SIZE];
  end

  block_subtract_bypass #(.W(BLOCK_SIZE)) u_slice (
    .a          (a_blocks[cnt_reg]),
    .b          (b_blocks[cnt_reg]),
    .borrow_in  (borrow_reg),
    .add        (op_reg),
    .diff       (blk_diff),
    .borrow_out (blk_borrow)
  );

  assign last_blk = (cnt_reg == CW'(LAST));

  // Overflow is judged on the final slice, whose MSB is the result sign.
  assign of_calc = op_reg
    ? ((a_reg[DATA_WIDTH-1] == b_reg[DATA_WIDTH-1]) & (blk_diff[BLOCK_SIZE-1] != a_reg[DATA_WIDTH-1]))
    : ((a_reg[DATA_WIDTH-1] != b_reg[DATA_WIDTH-1]) & (blk_diff[BLOCK_SIZE-1] != a_reg[DATA_WIDTH-1]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = BUSY;
      end
      BUSY: begin
        if (last_blk) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      d_reg      <= '0;
      borrow_reg <= 1'b0;
      bf_reg     <= 1'b0;
      of_reg     <= 1'b0;
      op_reg     <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg      <= A;
            b_reg      <= B;
            borrow_reg <= Bin;
            cnt_reg    <= '0;
`ifdef SUBTRACTOR_ADD_MODE_EN
            op_reg     <= op;
`else
            op_reg     <= 1'b0;
`endif
          end
        end
        BUSY: begin
          borrow_reg <= blk_borrow;
          cnt_reg    <= cnt_reg + CW'(1);
          for (int i = 0; i < STAGES; i++) begin
            if (cnt_reg == CW'(i)) d_reg[i*BLOCK_SIZE +: BLOCK_SIZE] <= blk_diff;
          end
          if (last_blk) begin
            bf_reg <= blk_borrow;
            of_reg <= of_calc;
          end
        end
        default: ;
      endcase
    end
  end

  assign D  = d_reg;
  assign BF = bf_reg;
  assign OF = of_reg;

endmodule
